// File: rtl/hazard_ctl.sv
// hazard_ctl: MIPS 5-stage pipeline stall/flush sequencer with saturating event counters
module hazard_ctl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rt,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             ifid_uses_rt,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_bubble,
    output logic             exmem_write,
    output logic             exmem_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [1:0]       state
);
    typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, FLUSH = 2'd2} state_t;
    localparam logic [2:0] FC_RELOAD = 3'(FLUSH_CYCLES - 1);
    state_t state_q, state_d;
    logic [2:0] fcount_q, fcount_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic stall_inc, flush_inc, load_use;
    assign load_use = idex_memread && idex_rt != 5'd0 &&
                      (idex_rt == ifid_rs || (ifid_uses_rt && idex_rt == ifid_rt));
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign state = state_q;
    always_comb begin
        pc_write = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        idex_write = 1'b1;
        idex_bubble = 1'b0;
        exmem_write = 1'b1;
        exmem_flush = 1'b0;
        state_d = state_q;
        fcount_d = fcount_q;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        case (state_q)
            RUN: begin
                if (branch_taken) begin
                    ifid_flush = 1'b1;
                    idex_bubble = 1'b1;
                    exmem_flush = 1'b1;
                    flush_inc = 1'b1;
                    state_d = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
                    fcount_d = FC_RELOAD;
                end else if (mem_busy) begin
                    {pc_write, ifid_write, idex_write, exmem_write} = 4'b0000;
                    stall_inc = 1'b1;
                    state_d = MEM_WAIT;
                end else if (load_use) begin
                    {pc_write, ifid_write, idex_bubble} = 3'b001;
                    stall_inc = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (mem_busy) begin
                    {pc_write, ifid_write, idex_write, exmem_write} = 4'b0000;
                    stall_inc = 1'b1;
                end else begin
                    state_d = RUN;
                    if (load_use) begin
                        {pc_write, ifid_write, idex_bubble} = 3'b001;
                        stall_inc = 1'b1;
                    end
                end
            end
            FLUSH: begin
                ifid_flush = 1'b1;
                idex_bubble = 1'b1;
                flush_inc = 1'b1;
                // A new taken branch restarts the squash window
                fcount_d = branch_taken ? FC_RELOAD : fcount_q - 3'd1;
                state_d = (!branch_taken && fcount_q <= 3'd1) ? RUN : FLUSH;
            end
            default: state_d = RUN;
        endcase
        stall_cnt_d = (stall_inc && stall_cnt_q != '1) ? stall_cnt_q + 1'b1 : stall_cnt_q;
        flush_cnt_d = (flush_inc && flush_cnt_q != '1) ? flush_cnt_q + 1'b1 : flush_cnt_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            fcount_q <= 3'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            fcount_q <= fcount_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end
endmodule

// File: tb/tb_hazard_ctl.sv
// tb_hazard_ctl: directed + random checks of two hazard_ctl configurations against a queue-free behavioural model
module tb_hazard_ctl;
    logic clk = 1'b0;
    logic rst, idex_memread, ifid_uses_rt, branch_taken, mem_busy;
    logic [4:0] idex_rt, ifid_rs, ifid_rt;
    logic [6:0] o [2];
    logic [1:0] s [2];
    logic [15:0] sc1, fc1;
    logic [3:0] sc3, fc3;
    int checks = 0;
    int failures = 0;
    int waitf [2], sq [2], st [2], fl [2];
    int fcy [2] = '{1, 3};
    int mx [2] = '{65535, 15};
    always #5 clk = ~clk;

    hazard_ctl #(.FLUSH_CYCLES(1), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst), .idex_memread(idex_memread), .idex_rt(idex_rt),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
        .branch_taken(branch_taken), .mem_busy(mem_busy),
        .pc_write(o[0][6]), .ifid_write(o[0][5]), .ifid_flush(o[0][4]), .idex_write(o[0][3]),
        .idex_bubble(o[0][2]), .exmem_write(o[0][1]), .exmem_flush(o[0][0]),
        .stall_cnt(sc1), .flush_cnt(fc1), .state(s[0]));
    hazard_ctl #(.FLUSH_CYCLES(3), .CNT_W(4)) u3 (
        .clk(clk), .rst(rst), .idex_memread(idex_memread), .idex_rt(idex_rt),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
        .branch_taken(branch_taken), .mem_busy(mem_busy),
        .pc_write(o[1][6]), .ifid_write(o[1][5]), .ifid_flush(o[1][4]), .idex_write(o[1][3]),
        .idex_bubble(o[1][2]), .exmem_write(o[1][1]), .exmem_flush(o[1][0]),
        .stall_cnt(sc3), .flush_cnt(fc3), .state(s[1]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output vector order: pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write, exmem_flush
    task automatic model(input int k, output logic [6:0] e);
        bit lu;
        lu = idex_memread && idex_rt != 0 && (idex_rt == ifid_rs || (ifid_uses_rt && idex_rt == ifid_rt));
        e = 7'b1101010;
        if (sq[k] > 0) begin
            e = 7'b1111110;
            fl[k]++;
            sq[k] = branch_taken ? fcy[k] - 1 : sq[k] - 1;
        end else if (waitf[k] != 0 && mem_busy) begin
            e = 7'b0000000;
            st[k]++;
        end else if (waitf[k] == 0 && branch_taken) begin
            e = 7'b1111111;
            fl[k]++;
            sq[k] = fcy[k] - 1;
        end else if (waitf[k] == 0 && mem_busy) begin
            e = 7'b0000000;
            st[k]++;
            waitf[k] = 1;
        end else begin
            waitf[k] = 0;
            if (lu) begin
                e = 7'b0001110;
                st[k]++;
            end
        end
        if (st[k] > mx[k]) st[k] = mx[k];
        if (fl[k] > mx[k]) fl[k] = mx[k];
    endtask

    task automatic drive(input logic r, mr, input logic [4:0] xrt, rs, rt,
                         input logic ur, br, mb);
        logic [6:0] e;
        int es;
        rst = r; idex_memread = mr; idex_rt = xrt; ifid_rs = rs; ifid_rt = rt;
        ifid_uses_rt = ur; branch_taken = br; mem_busy = mb;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            es = waitf[k] != 0 ? 1 : (sq[k] > 0 ? 2 : 0);
            chk($sformatf("state%0d", k), 32'(s[k]), 32'(es));
            chk($sformatf("stall_cnt%0d", k), k == 0 ? 32'(sc1) : 32'(sc3), 32'(st[k]));
            chk($sformatf("flush_cnt%0d", k), k == 0 ? 32'(fc1) : 32'(fc3), 32'(fl[k]));
            if (r) begin
                waitf[k] = 0; sq[k] = 0; st[k] = 0; fl[k] = 0;
            end else begin
                model(k, e);
                chk($sformatf("ctl%0d", k), 32'(o[k]), 32'(e));
            end
        end
        @(posedge clk);
        #1;
        if (r) begin
            chk("rst_state", {s[0], s[1]}, 0);
            chk("rst_cnt", {sc1, fc1, sc3, fc3}, 0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        drive(0, 1, 8, 8, 0, 0, 0, 0);
        idle(1);
        chk("lu_stall_cnt", 32'(sc1), 1);
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 9, 1, 9, 0, 0, 0);
        drive(0, 1, 9, 1, 9, 1, 0, 0);
        idle(1);
        chk("rt_stall_cnt", 32'(sc1), 2);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0, 0, 1);
        chk("mw_state", 32'(s[0]), 1);
        chk("mw_stall_cnt", 32'(sc1), 3);
        idle(2);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 8, 8, 0, 0, 1, 0);
        chk("br_flush_cnt", 32'(fc1), 1);
        chk("br_stall_cnt", 32'(sc1), 0);
        idle(3);
        chk("fl3_flush_cnt", 32'(fc3), 3);
        chk("fl3_state", 32'(s[1]), 0);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        idle(1);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        for (int i = 0; i < 20; i++) drive(0, 0, 0, 0, 0, 0, 0, 1);
        chk("sat_stall_cnt", 32'(sc3), 15);
        idle(2);
        for (int i = 0; i < 600; i++)
            drive($urandom_range(99) == 0, $urandom_range(1), 5'($urandom_range(3)),
                  5'($urandom_range(3)), 5'($urandom_range(3)), $urandom_range(1),
                  $urandom_range(9) == 0, $urandom_range(5) == 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
